// File: rtl/rv32_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_pipeline_ctrl
// Central stall/flush controller for the 5-stage rv32 pipeline
// (fetch, decode, execute, mem, writeback).
//
// Parameters
//   MEM_TIMEOUT          max cycles a mem access may wait on data_ready (>=1)
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   decode_rs1/rs2       source register indices of the instruction in decode
//   execute_mem_read_en  instruction entering execute is a load
//   execute_rd           destination of the instruction entering execute
//   mem_read_en/write_en mem-stage instruction is a load / store
//   data_ready           data bus completes the mem-stage access this cycle
//   branch_taken         mem-stage branch resolved taken
//   instr_ready          instruction bus returns a fetch word this cycle
//   stall_*              hold the named pipeline register (combinational)
//   flush_*              load a bubble into the named register (combinational)
//   bus_error            registered one-cycle pulse after an access timeout
//   stall_count          registered count of cycles with stall_fetch=1
// ---------------------------------------------------------------------------
module rv32_pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  decode_rs1,
    input  logic [4:0]  decode_rs2,
    input  logic        execute_mem_read_en,
    input  logic [4:0]  execute_rd,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic        data_ready,
    input  logic        branch_taken,
    input  logic        instr_ready,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        stall_execute,
    output logic        stall_mem,
    output logic        flush_decode,
    output logic        flush_execute,
    output logic        flush_mem,
    output logic        flush_writeback,
    output logic        bus_error,
    output logic [31:0] stall_count
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            bus_error_q, bus_error_d;
    logic [31:0]     stall_count_q, stall_count_d;

    logic mem_access_s;
    logic load_use_s;
    logic bus_wait_s;

    assign mem_access_s = mem_read_en | mem_write_en;
    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign load_use_s   = execute_mem_read_en & (|execute_rd) &
                          ((execute_rd == decode_rs1) | (execute_rd == decode_rs2));
    // A first-cycle access with data_ready=1 completes immediately and never waits.
    assign bus_wait_s   = ((state_q == ST_RUN) & mem_access_s & ~data_ready) |
                          ((state_q == ST_MEM_WAIT) & ~data_ready);

    // Bus-wait FSM next state, wait counter and timeout pulse.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_access_s && !data_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (data_ready) begin
                    state_d    = ST_RUN;
                end else if (wait_cnt_q == CNT_LIMIT) begin
                    state_d    = ST_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_TIMEOUT: begin
                bus_error_d = 1'b1;
                state_d     = ST_RUN;
                wait_cnt_d  = CNT_ZERO;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Stall/flush decode; rows are evaluated in priority order.
    always_comb begin
        stall_fetch     = 1'b0;
        stall_decode    = 1'b0;
        stall_execute   = 1'b0;
        stall_mem       = 1'b0;
        flush_decode    = 1'b0;
        flush_execute   = 1'b0;
        flush_mem       = 1'b0;
        flush_writeback = 1'b0;
        if (reset) begin
            flush_decode    = 1'b1;
            flush_execute   = 1'b1;
            flush_mem       = 1'b1;
            flush_writeback = 1'b1;
        end else begin
            // Abandoned access must not write back; lower rows still apply.
            if (state_q == ST_TIMEOUT) begin
                flush_writeback = 1'b1;
            end else begin
                flush_writeback = 1'b0;
            end
            if (bus_wait_s) begin
                // The branch (if any) stays parked in mem until the bus releases.
                stall_fetch     = 1'b1;
                stall_decode    = 1'b1;
                stall_execute   = 1'b1;
                stall_mem       = 1'b1;
                flush_writeback = 1'b1;
            end else if (branch_taken) begin
                flush_decode    = 1'b1;
                flush_execute   = 1'b1;
                flush_mem       = 1'b1;
            end else if (load_use_s) begin
                // One bubble suffices: the load reaches mem and forwarding covers the use.
                stall_fetch     = 1'b1;
                stall_decode    = 1'b1;
                flush_execute   = 1'b1;
            end else if (!instr_ready) begin
                stall_fetch     = 1'b1;
                flush_decode    = 1'b1;
            end else begin
                stall_fetch     = 1'b0;
            end
        end
    end

    // Stall cycle counter, wraps naturally at 32 bits.
    always_comb begin
        if (stall_fetch) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= CNT_ZERO;
            bus_error_q   <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_error_q   <= bus_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus_error   = bus_error_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_pipeline_ctrl
// Directed bench for rv32_pipeline_ctrl with MEM_TIMEOUT=4. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rv32_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  decode_rs1, decode_rs2, execute_rd;
    logic        execute_mem_read_en, mem_read_en, mem_write_en;
    logic        data_ready, branch_taken, instr_ready;
    logic        stall_fetch, stall_decode, stall_execute, stall_mem;
    logic        flush_decode, flush_execute, flush_mem, flush_writeback;
    logic        bus_error;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] stall_v, flush_v;
    assign stall_v = {stall_fetch, stall_decode, stall_execute, stall_mem};
    assign flush_v = {flush_decode, flush_execute, flush_mem, flush_writeback};

    rv32_pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .decode_rs1         (decode_rs1),
        .decode_rs2         (decode_rs2),
        .execute_mem_read_en(execute_mem_read_en),
        .execute_rd         (execute_rd),
        .mem_read_en        (mem_read_en),
        .mem_write_en       (mem_write_en),
        .data_ready         (data_ready),
        .branch_taken       (branch_taken),
        .instr_ready        (instr_ready),
        .stall_fetch        (stall_fetch),
        .stall_decode       (stall_decode),
        .stall_execute      (stall_execute),
        .stall_mem          (stall_mem),
        .flush_decode       (flush_decode),
        .flush_execute      (flush_execute),
        .flush_mem          (flush_mem),
        .flush_writeback    (flush_writeback),
        .bus_error          (bus_error),
        .stall_count        (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check the control vectors at the falling edge of the current cycle.
    task automatic chk_ctl(input string tag, input logic [3:0] exp_stall, input logic [3:0] exp_flush);
        @(negedge clk);
        chk({tag, ".stall"}, {28'd0, stall_v}, {28'd0, exp_stall});
        chk({tag, ".flush"}, {28'd0, flush_v}, {28'd0, exp_flush});
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        decode_rs1          = 5'd0;
        decode_rs2          = 5'd0;
        execute_rd          = 5'd0;
        execute_mem_read_en = 1'b0;
        mem_read_en         = 1'b0;
        mem_write_en        = 1'b0;
        data_ready          = 1'b0;
        branch_taken        = 1'b0;
        instr_ready         = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        next_cyc();
        next_cyc();
        chk_ctl("reset_ctl", 4'b0000, 4'b1111);
        chk("reset_bus_error", {31'd0, bus_error}, 32'd0);
        chk("reset_count", stall_count, 32'd0);

        next_cyc(); reset = 1'b0; idle();
        chk_ctl("idle", 4'b0000, 4'b0000);

        // load x5 in execute, decode rs1=x5
        next_cyc(); execute_mem_read_en = 1'b1; execute_rd = 5'd5; decode_rs1 = 5'd5;
        chk_ctl("load_use_rs1", 4'b1100, 4'b0100);
        next_cyc(); idle();
        chk_ctl("load_use_after", 4'b0000, 4'b0000);
        chk("count_lu1", stall_count, 32'd1);

        // rs2 match
        next_cyc(); execute_mem_read_en = 1'b1; execute_rd = 5'd7; decode_rs2 = 5'd7; decode_rs1 = 5'd3;
        chk_ctl("load_use_rs2", 4'b1100, 4'b0100);

        // rd=x0 never hazards
        next_cyc(); idle(); execute_mem_read_en = 1'b1; execute_rd = 5'd0; decode_rs1 = 5'd0;
        chk_ctl("load_x0", 4'b0000, 4'b0000);
        chk("count_lu2", stall_count, 32'd2);

        // fetch wait
        next_cyc(); idle(); instr_ready = 1'b0;
        chk_ctl("fetch_wait", 4'b1000, 4'b1000);
        next_cyc(); idle();
        chk_ctl("fetch_resume", 4'b0000, 4'b0000);
        chk("count_fetch", stall_count, 32'd3);

        // store held 3 cycles by the data bus, released on the 4th
        for (int i = 0; i < 3; i++) begin
            next_cyc(); idle(); mem_write_en = 1'b1;
            chk_ctl("store_wait", 4'b1111, 4'b0001);
        end
        next_cyc(); data_ready = 1'b1;
        chk_ctl("store_release", 4'b0000, 4'b0000);
        chk("count_store", stall_count, 32'd6);

        // branch beats load_use and fetch wait
        next_cyc(); idle(); branch_taken = 1'b1; instr_ready = 1'b0;
        execute_mem_read_en = 1'b1; execute_rd = 5'd9; decode_rs1 = 5'd9;
        chk_ctl("branch_prio", 4'b0000, 4'b1110);
        next_cyc(); idle();
        chk_ctl("branch_after", 4'b0000, 4'b0000);
        chk("count_branch", stall_count, 32'd6);

        // timeout: 5 stalled cycles, TIMEOUT cycle, then bus_error pulse
        for (int i = 0; i < 5; i++) begin
            next_cyc(); idle(); mem_read_en = 1'b1;
            chk_ctl("timeout_wait", 4'b1111, 4'b0001);
            chk("timeout_no_err", {31'd0, bus_error}, 32'd0);
        end
        next_cyc(); idle();
        chk_ctl("timeout_state", 4'b0000, 4'b0001);
        chk("timeout_err_early", {31'd0, bus_error}, 32'd0);
        next_cyc();
        chk_ctl("timeout_run", 4'b0000, 4'b0000);
        chk("timeout_err_pulse", {31'd0, bus_error}, 32'd1);
        chk("count_timeout", stall_count, 32'd11);
        next_cyc();
        chk_ctl("timeout_idle", 4'b0000, 4'b0000);
        chk("timeout_err_clear", {31'd0, bus_error}, 32'd0);

        // data_ready on the first cycle: no stall, stays in RUN
        next_cyc(); mem_read_en = 1'b1; data_ready = 1'b1;
        chk_ctl("fast_access", 4'b0000, 4'b0000);
        next_cyc(); idle();
        chk_ctl("fast_after", 4'b0000, 4'b0000);

        // branch arriving during bus wait honoured only when data_ready rises
        next_cyc(); mem_read_en = 1'b1;
        chk_ctl("br_wait0", 4'b1111, 4'b0001);
        next_cyc(); branch_taken = 1'b1;
        chk_ctl("br_wait1", 4'b1111, 4'b0001);
        next_cyc(); data_ready = 1'b1;
        chk_ctl("br_wait2", 4'b0000, 4'b1110);
        next_cyc(); idle();
        chk_ctl("br_wait_after", 4'b0000, 4'b0000);
        chk("count_br_wait", stall_count, 32'd13);

        // reset pulse during MEM_WAIT
        next_cyc(); mem_write_en = 1'b1;
        chk_ctl("rst_wait0", 4'b1111, 4'b0001);
        next_cyc(); reset = 1'b1;
        chk_ctl("rst_high", 4'b0000, 4'b1111);
        next_cyc(); reset = 1'b0; idle();
        chk_ctl("rst_run", 4'b0000, 4'b0000);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk("rst_count", stall_count, 32'd0);
        next_cyc();
        chk_ctl("rst_run2", 4'b0000, 4'b0000);
        chk("rst_bus_error2", {31'd0, bus_error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
